subtractor_64bit: RTL and testbench
===================================

Name: subtractor_64bit

Overview:
- 64-bit two's-complement subtractor for the Y86-64 SEQ Execute-stage ALU.
- Computes A − B as A + ~B + 1 through a bit-level full-adder chain with carry-in 1, and flags signed overflow.
- Operands are sampled on the rising clock edge, and results are registered with one-cycle latency.

Parameters:
- WIDTH, 64, operand and result width in bits. Only 64 is required to be supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operands A/B are valid this cycle.
- A  input  64  minuend, two's complement.
- B  input  64  subtrahend, two's complement.
- Sum  output  64  registered difference A − B, mod 2^64.
- carry_overflow  output  1  registered signed-overflow flag for this difference.
- out_valid  output  1  Sum/carry_overflow hold a fresh result this cycle.

Behaviour:
- Reset:
  - rst_n is sampled only on the rising edge of clk.
  - rst_n=0 at an edge: Sum=0, carry_overflow=0, out_valid=0.
  - Reset dominates in_valid, including when an operation is in flight; that result is discarded.
- Datapath:
  - Combinational diff = A + (~B) + 1, using a ripple chain of 64 one-bit full adders with c[0]=1.
  - Final carry-out c[64] is internal only and is not an output.
- Overflow:
  - ovf = (A[63] != B[63]) && (diff[63] != A[63]).
  - Equivalently, ovf = c[63] XOR c[64] of the chain.
  - Unsigned borrow does NOT set carry_overflow.
- Latency:
  - At an edge with rst_n=1 and in_valid=1: Sum<=diff, carry_overflow<=ovf, out_valid<=1.
  - Results are visible one cycle after operands are sampled.
- Idle:
  - At an edge with rst_n=1 and in_valid=0: Sum and carry_overflow hold their previous values; out_valid<=0.
- Throughput:
  - One operation per cycle; back-to-back in_valid is fully pipelined.
  - Each result corresponds to the operands of the preceding accepted edge.
- Wrap-around:
  - Results are modulo 2^64 with no saturation.
  - 0 − 1 = 0xFFFF_FFFF_FFFF_FFFF with ovf=0.
  - 0x8000_0000_0000_0000 − 1 = 0x7FFF_FFFF_FFFF_FFFF with ovf=1.
- Edge cases:
  - A == B gives Sum=0, ovf=0.
  - B = 0x8000_0000_0000_0000 with A ≥ 0 gives ovf=1.
  - B = 0x8000_0000_0000_0000 with A < 0 gives ovf=0.
- Purity:
  - No X propagation from the idle path; outputs are always driven from registers.
  - Inputs are not required to be stable between accepted edges.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, A=5, B=3 -> Sum=0, carry_overflow=0, out_valid=0. Release rst_n -> the next edge gives Sum=2, out_valid=1.
- Small negative result: A=9, B=10, in_valid=1 -> after 1 edge Sum=0xFFFF_FFFF_FFFF_FFFF (signed −1), carry_overflow=0, out_valid=1.
- Mixed-sign patterns: A=0xF0F0_F0F0_F0F0_F0F0, B=0x0F0F_0F0F_0F0F_0F0F -> Sum=0xE1E1_E1E1_E1E1_E1E1, carry_overflow=0.
- Positive results and sign flip, back-to-back: A=100,B=50 then A=50,B=100 on consecutive cycles -> Sum=50 then Sum=0xFFFF_FFFF_FFFF_FFCE (−50), carry_overflow=0 both, out_valid=1 both cycles.
- Signed overflow:
  - A=0x7FFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF -> Sum=0x8000_0000_0000_0000, carry_overflow=1.
  - A=0x8000_0000_0000_0000, B=1 -> Sum=0x7FFF_FFFF_FFFF_FFFF, carry_overflow=1.
- Hold/idle, then mid-stream reset:
  - After a result, drop in_valid and change A/B -> Sum/carry_overflow unchanged, out_valid=0.
  - Assert rst_n=0 for one edge during a valid stream -> all outputs 0 on that edge.

Source files
------------

// File: rtl/subtractor_64bit.sv
// subtractor_64bit: registered A - B via a ripple full-adder chain with signed-overflow flag
module subtractor_64bit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             carry_overflow,
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] diff;
    logic             ovf;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    assign c[0] = 1'b1;
    assign nb   = ~B;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign diff[i]  = A[i] ^ nb[i] ^ c[i];
        assign c[i + 1] = (A[i] & nb[i]) | (c[i] & (A[i] ^ nb[i]));
    end

    // Signed overflow: carry into the sign bit disagrees with carry out of it
    assign ovf = c[WIDTH-1] ^ c[WIDTH];

    always_comb begin
        sum_d   = in_valid ? diff : sum_q;
        ovf_d   = in_valid ? ovf : ovf_q;
        valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign Sum            = sum_q;
    assign carry_overflow = ovf_q;
    assign out_valid      = valid_q;
endmodule

// File: tb/tb_subtractor_64bit.sv
// tb_subtractor_64bit: directed and random stimulus checked against a plain-arithmetic model
module tb_subtractor_64bit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] A, B;
    logic [63:0] Sum;
    logic        carry_overflow;
    logic        out_valid;
    logic [63:0] m_sum;
    logic        m_ovf;
    logic        m_vld;
    int          checks = 0;
    int          errors = 0;

    subtractor_64bit dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .A(A),
        .B(B),
        .Sum(Sum),
        .carry_overflow(carry_overflow),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one edge, advance the reference model, compare all outputs
    task automatic cycle(input logic rn, input logic v, input logic [63:0] a, input logic [63:0] b);
        logic signed [64:0] wide;
        rst_n    = rn;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        if (!rn) begin
            m_sum = '0;
            m_ovf = 1'b0;
            m_vld = 1'b0;
        end else if (v) begin
            m_sum = a - b;
            wide  = $signed({a[63], a}) - $signed({b[63], b});
            m_ovf = wide > 65'sd9223372036854775807 || wide < -65'sd9223372036854775808;
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        chk("sum", Sum, m_sum);
        chk("ovf", 64'(carry_overflow), 64'(m_ovf));
        chk("vld", 64'(out_valid), 64'(m_vld));
    endtask

    initial begin
        logic [63:0] ra, rb;
        m_sum = '0;
        m_ovf = 1'b0;
        m_vld = 1'b0;
        cycle(1'b0, 1'b1, 64'd5, 64'd3);
        cycle(1'b0, 1'b1, 64'd5, 64'd3);
        chk("rst_sum", Sum, 64'd0);
        chk("rst_vld", 64'(out_valid), 64'd0);
        cycle(1'b1, 1'b1, 64'd5, 64'd3);
        chk("rel_sum", Sum, 64'd2);
        chk("rel_vld", 64'(out_valid), 64'd1);
        cycle(1'b1, 1'b1, 64'd9, 64'd10);
        chk("neg1", Sum, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(1'b1, 1'b1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F);
        chk("mixed", Sum, 64'hE1E1_E1E1_E1E1_E1E1);
        cycle(1'b1, 1'b1, 64'd100, 64'd50);
        chk("pos50", Sum, 64'd50);
        cycle(1'b1, 1'b1, 64'd50, 64'd100);
        chk("neg50", Sum, 64'hFFFF_FFFF_FFFF_FFCE);
        cycle(1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf_pos", 64'(carry_overflow), 64'd1);
        chk("ovf_pos_sum", Sum, 64'h8000_0000_0000_0000);
        cycle(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd1);
        chk("ovf_neg", 64'(carry_overflow), 64'd1);
        chk("ovf_neg_sum", Sum, 64'h7FFF_FFFF_FFFF_FFFF);
        cycle(1'b1, 1'b0, 64'd123, 64'd456);
        chk("hold_sum", Sum, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("hold_ovf", 64'(carry_overflow), 64'd1);
        cycle(1'b1, 1'b1, 64'd0, 64'd1);
        chk("borrow_no_ovf", 64'(carry_overflow), 64'd0);
        cycle(1'b0, 1'b1, 64'd77, 64'd7);
        chk("mid_rst", Sum, 64'd0);
        cycle(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
        chk("eq", Sum, 64'd0);
        cycle(1'b1, 1'b1, 64'd3, 64'h8000_0000_0000_0000);
        chk("bmin_apos", 64'(carry_overflow), 64'd1);
        cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0000);
        chk("bmin_aneg", 64'(carry_overflow), 64'd0);
        for (int n = 0; n < 400; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = 64'h8000_0000_0000_0000;
                1: ra = 64'h7FFF_FFFF_FFFF_FFFF;
                2: rb = ra;
                3: ra = 64'h8000_0000_0000_0000;
                default: ;
            endcase
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, ra, rb);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
